// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT bit-reversal reorder stage.
package fft_reorder_pkg;

  localparam int unsigned DefaultLog2N = 6;

  typedef enum logic {IDLE, READ} rd_state_t;

  // Reverse the low log2n bits of value; upper result bits are zero.
  function automatic int unsigned bitrev(input int unsigned value, input int unsigned log2n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < log2n; i++) begin
      r[i] = value[log2n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module reorder_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [2**AddrWidth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; it holds its value between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural order.
// Optional start-of-frame output do_sof enabled by defining FFT_REORDER_SOF_EN.
module fft_bitrev_reorder
  import fft_reorder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG2N = DefaultLog2N
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
`ifdef FFT_REORDER_SOF_EN
  ,
  output logic             do_sof
`endif
);

  localparam int unsigned N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_addr_q, rd_addr_d;
  logic             do_en_q;
  logic             wr_last, rd_issue, rd_last;
  logic [LOG2N-1:0] wr_addr_rev;
  logic [2*WIDTH-1:0] rd_data;

  assign wr_addr_rev = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));

  always_comb begin
    wr_last   = di_en && (wr_cnt_q == LastIdx);
    wr_cnt_d  = di_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ wr_last;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_addr_d  = rd_addr_q;
    rd_issue   = 1'b0;
    rd_last    = 1'b0;
    case (rd_state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = READ;
          rd_addr_d  = '0;
        end
      end
      READ: begin
        rd_issue  = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LastIdx) begin
          rd_last   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          // A frame completing into the other bank this cycle also counts as full.
          if (full_q[~rd_bank_q] || (wr_last && (wr_bank_q != rd_bank_q))) begin
            rd_state_d = READ;
          end else begin
            rd_state_d = IDLE;
          end
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  // Clear and set target different banks, so both take effect.
  always_comb begin
    full_d = full_q;
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      rd_state_q <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      do_en_q    <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      do_en_q    <= rd_issue;
    end
  end

  reorder_ram #(
    .DataWidth(2 * WIDTH),
    .AddrWidth(LOG2N + 1)
  ) u_ram (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (di_en),
    .waddr  ({wr_bank_q, wr_addr_rev}),
    .wdata  ({di_re, di_im}),
    .re     (rd_issue),
    .raddr  ({rd_bank_q, rd_addr_q}),
    .rdata  (rd_data)
  );

  assign do_en = do_en_q;
  assign do_re = rd_data[2*WIDTH-1:WIDTH];
  assign do_im = rd_data[WIDTH-1:0];

`ifdef FFT_REORDER_SOF_EN
  logic do_sof_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      do_sof_q <= 1'b0;
    end else begin
      do_sof_q <= rd_issue && (rd_addr_q == '0);
    end
  end

  assign do_sof = do_sof_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at LOG2N=3 and LOG2N=6.
module tb_fft_bitrev_reorder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        di_en3 = 1'b0, di_en6 = 1'b0;
  logic [15:0] di_re3 = '0, di_im3 = '0, di_re6 = '0, di_im6 = '0;
  logic        do_en3, do_en6;
  logic [15:0] do_re3, do_im3, do_re6, do_im6;
  logic        do_sof3, do_sof6;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int          log3_cyc[$], log6_cyc[$];
  logic [15:0] log3_re[$], log3_im[$], log6_re[$], log6_im[$];
  logic        log3_sof[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifndef FFT_REORDER_SOF_EN
  assign do_sof3 = 1'b0;
  assign do_sof6 = 1'b0;
`endif

  fft_bitrev_reorder #(.WIDTH(16), .LOG2N(3)) u_dut3 (
    .clock  (clock),
    .reset_n(reset_n),
    .di_en  (di_en3),
    .di_re  (di_re3),
    .di_im  (di_im3),
    .do_en  (do_en3),
    .do_re  (do_re3),
    .do_im  (do_im3)
`ifdef FFT_REORDER_SOF_EN
    ,
    .do_sof (do_sof3)
`endif
  );

  fft_bitrev_reorder #(.WIDTH(16), .LOG2N(6)) u_dut6 (
    .clock  (clock),
    .reset_n(reset_n),
    .di_en  (di_en6),
    .di_re  (di_re6),
    .di_im  (di_im6),
    .do_en  (do_en6),
    .do_re  (do_re6),
    .do_im  (do_im6)
`ifdef FFT_REORDER_SOF_EN
    ,
    .do_sof (do_sof6)
`endif
  );

  always @(negedge clock) begin
    if (do_en3) begin
      log3_cyc.push_back(cyc);
      log3_re.push_back(do_re3);
      log3_im.push_back(do_im3);
      log3_sof.push_back(do_sof3);
    end
    if (do_en6) begin
      log6_cyc.push_back(cyc);
      log6_re.push_back(do_re6);
      log6_im.push_back(do_im6);
    end
  end

  function automatic int rev(input int v, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) if ((v >> i) & 1) r |= 1 << (n - 1 - i);
    return r;
  endfunction

  task automatic clear_logs();
    log3_cyc.delete(); log3_re.delete(); log3_im.delete(); log3_sof.delete();
    log6_cyc.delete(); log6_re.delete(); log6_im.delete();
  endtask

  // Inputs change at negedge; the following posedge (edge cyc+1) accepts them.
  task automatic drive3(input logic en, input int v);
    @(negedge clock);
    di_en3 = en;
    di_re3 = 16'(v);
    di_im3 = 16'(-v);
  endtask

  task automatic idle3(input int n);
    for (int i = 0; i < n; i++) drive3(1'b0, 0);
  endtask

  task automatic send3(input int offset, input bit gapped, input int count,
                       output int t_first, output int t_last);
    t_first = 0;
    t_last = 0;
    for (int k = 0; k < count; k++) begin
      drive3(1'b1, rev(k, 3) + offset);
      if (k == 0) t_first = cyc + 1;
      t_last = cyc + 1;
      if (gapped) drive3(1'b0, 0);
    end
  endtask

  // Expects 8*frames natural-order outputs on consecutive cycles from t_out.
  task automatic check_frames3(input string name, input int t_out, input int frames);
    int exp_v;
    tests_run++;
    if (log3_re.size() !== 8 * frames) begin
      tests_failed++;
      $display("FAIL %s count: got %0d outputs, expected %0d", name, log3_re.size(), 8 * frames);
    end
    for (int j = 0; j < 8 * frames && j < log3_re.size(); j++) begin
      exp_v = (j % 8) + 100 * (j / 8);
      if (name == "reset_mid") exp_v = j + 20;
      tests_run++;
      if (log3_cyc[j] !== t_out + j) begin
        tests_failed++;
        $display("FAIL %s cycle[%0d]: got %0d expected %0d", name, j, log3_cyc[j], t_out + j);
      end
      tests_run++;
      if (log3_re[j] !== 16'(exp_v)) begin
        tests_failed++;
        $display("FAIL %s re[%0d]: got %0d expected %0d", name, j, log3_re[j], exp_v);
      end
      tests_run++;
      if (log3_im[j] !== 16'(-exp_v)) begin
        tests_failed++;
        $display("FAIL %s im[%0d]: got %0h expected %0h", name, j, log3_im[j], 16'(-exp_v));
      end
`ifdef FFT_REORDER_SOF_EN
      tests_run++;
      if (log3_sof[j] !== ((j % 8) == 0)) begin
        tests_failed++;
        $display("FAIL %s sof[%0d]: got %0b expected %0b", name, j, log3_sof[j], (j % 8) == 0);
      end
`endif
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({do_en3, do_re3, do_im3} !== 33'd0) begin
      tests_failed++;
      $display("FAIL reset_dut3: got en=%0b re=%0h im=%0h expected all 0", do_en3, do_re3, do_im3);
    end
    tests_run++;
    if ({do_en6, do_re6, do_im6} !== 33'd0) begin
      tests_failed++;
      $display("FAIL reset_dut6: got en=%0b re=%0h im=%0h expected all 0", do_en6, do_re6, do_im6);
    end
    tests_run++;
    if ({do_sof3, do_sof6} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_sof: got %0b%0b expected 00", do_sof3, do_sof6);
    end
    reset_n = 1'b1;
    clear_logs();
    idle3(10);
    tests_run++;
    if (log3_re.size() + log6_re.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %0d outputs expected 0", log3_re.size() + log6_re.size());
    end
  endtask

  task automatic test_single_frame();
    int t0, tl;
    clear_logs();
    send3(0, 1'b0, 8, t0, tl);
    idle3(16);
    check_frames3("single", t0 + 9, 1);
  endtask

  task automatic test_back_to_back();
    int t0, tl, ta, tb;
    clear_logs();
    send3(0, 1'b0, 8, t0, tl);
    send3(100, 1'b0, 8, ta, tb);
    send3(200, 1'b0, 8, ta, tb);
    idle3(20);
    check_frames3("back_to_back", t0 + 9, 3);
  endtask

  task automatic test_gapped();
    int t0, tl;
    clear_logs();
    send3(0, 1'b1, 8, t0, tl);
    idle3(16);
    check_frames3("gapped", tl + 2, 1);
  endtask

  task automatic test_reset_mid_frame();
    int t0, tl;
    bit seen = 1'b0;
    // Reset while a frame streams out: do_en must drop without a clock edge.
    send3(0, 1'b0, 8, t0, tl);
    for (int i = 0; i < 40 && !seen; i++) begin
      drive3(1'b0, 0);
      seen = do_en3;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL reset_mid wait_en: got do_en never high expected high within 40 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (do_en3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid async_drop: got do_en=%0b expected 0", do_en3);
    end
    @(negedge clock);
    reset_n = 1'b1;
    clear_logs();
    send3(50, 1'b0, 5, t0, tl);
    @(negedge clock);
    di_en3 = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle3(16);
    tests_run++;
    if (log3_re.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid partial: got %0d outputs expected 0", log3_re.size());
    end
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      drive3(1'b1, rev(k, 3) + 20);
      if (k == 0) t0 = cyc + 1;
    end
    idle3(16);
    check_frames3("reset_mid", t0 + 9, 1);
  endtask

  task automatic test_log2n6();
    logic [15:0] nat_re[64], nat_im[64];
    logic [15:0] exp_re[$], exp_im[$];
    logic [15:0] r, m;
    int t0 = 0;
    clear_logs();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 64; k++) begin
        r = 16'($urandom);
        m = 16'($urandom);
        @(negedge clock);
        di_en6 = 1'b1;
        di_re6 = r;
        di_im6 = m;
        if (f == 0 && k == 0) t0 = cyc + 1;
        nat_re[rev(k, 6)] = r;
        nat_im[rev(k, 6)] = m;
      end
      for (int j = 0; j < 64; j++) begin
        exp_re.push_back(nat_re[j]);
        exp_im.push_back(nat_im[j]);
      end
    end
    @(negedge clock);
    di_en6 = 1'b0;
    repeat (80) @(negedge clock);
    tests_run++;
    if (log6_re.size() !== 256) begin
      tests_failed++;
      $display("FAIL log2n6 count: got %0d outputs expected 256", log6_re.size());
    end
    for (int i = 0; i < 256 && i < log6_re.size(); i++) begin
      tests_run++;
      if (log6_cyc[i] !== t0 + 65 + i) begin
        tests_failed++;
        $display("FAIL log2n6 cycle[%0d]: got %0d expected %0d", i, log6_cyc[i], t0 + 65 + i);
      end
      tests_run++;
      if ({log6_re[i], log6_im[i]} !== {exp_re[i], exp_im[i]}) begin
        tests_failed++;
        $display("FAIL log2n6 data[%0d]: got %0h/%0h expected %0h/%0h", i, log6_re[i],
                 log6_im[i], exp_re[i], exp_im[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_log2n6();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
